gaussian_stats_accum: RTL

//  Receive end of the 128-bit sim_data noise stream from the Gaussian LFSR generator. Accumulates
//  sum, sum-of-squares, min and max of the 12b samples over a programmable window of words.

---
 rtl/gaussian_stats_pkg.sv | 28 ++
 rtl/gaussian_stats_lane.sv | 28 ++
 rtl/gaussian_stats_accum.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/gaussian_stats_pkg.sv
// Shared constants, FSM state type and lane extraction helper for the
// Gaussian noise statistics accumulator.
package gaussian_stats_pkg;

   localparam int SAMPLE_W = 12;
   localparam int LANE_W   = 16;
   localparam int LANES    = 8;
   localparam int SQ_W     = 23;
   localparam int TREE_W   = SAMPLE_W + 3;   // sum of 8 samples

   localparam logic signed [SAMPLE_W-1:0] MIN_INIT = 12'sh7FF;
   localparam logic signed [SAMPLE_W-1:0] MAX_INIT = 12'sh800;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   function automatic logic signed [SAMPLE_W-1:0] lane_sample(
      input logic [LANES*LANE_W-1:0] word,
      input int                      k
   );
      return word[LANE_W*k +: SAMPLE_W];
   endfunction

endpackage

// File: rtl/gaussian_stats_lane.sv
// One 16b lane: sign-extends the 12b sample, squares it and folds it into
// a min/max compare chain.
module gaussian_stats_lane
   import gaussian_stats_pkg::*;
(
   input  logic signed [SAMPLE_W-1:0] sample,
   input  logic signed [SAMPLE_W-1:0] min_in,
   input  logic signed [SAMPLE_W-1:0] max_in,
   output logic signed [TREE_W-1:0]   ext,
   output logic        [SQ_W-1:0]     square,
   output logic signed [SAMPLE_W-1:0] min_out,
   output logic signed [SAMPLE_W-1:0] max_out
);

   logic [SAMPLE_W-1:0] mag;
   logic [SQ_W-1:0]     mag_w;

   assign ext = {{(TREE_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};

   // |-2048| = 2048 still fits 12 unsigned bits, so squaring the magnitude is exact
   assign mag    = sample[SAMPLE_W-1] ? SAMPLE_W'(-sample) : SAMPLE_W'(sample);
   assign mag_w  = SQ_W'(mag);
   assign square = mag_w * mag_w;

   assign min_out = (sample < min_in) ? sample : min_in;
   assign max_out = (sample > max_in) ? sample : max_in;

endmodule

// File: rtl/gaussian_stats_accum.sv
// Windowed sum / sum-of-squares / min / max of the 128b noise stream.
// Optional 16-bin histogram enabled by defining GAUSS_STATS_HIST_EN.
module gaussian_stats_accum
   import gaussian_stats_pkg::*;
#(
   parameter int LOG2_WORDS = 10
)(
   input  logic                              clk,
   input  logic                              rst_i,
   input  logic [LANES*LANE_W-1:0]           sim_data,
   input  logic                              valid_i,
   input  logic                              start_i,
   input  logic                              ack_i,
   output logic                              busy_o,
   output logic                              done_o,
   output logic signed [TREE_W+LOG2_WORDS-1:0] sum_o,
   output logic [SQ_W+3+LOG2_WORDS-1:0]      sumsq_o,
   output logic signed [SAMPLE_W-1:0]        min_o,
   output logic signed [SAMPLE_W-1:0]        max_o
`ifdef GAUSS_STATS_HIST_EN
   ,
   input  logic [3:0]                        hist_sel_i,
   output logic [LOG2_WORDS+3:0]             hist_cnt_o
`endif
);

   localparam int SUM_W = TREE_W + LOG2_WORDS;
   localparam int TSQ_W = SQ_W + 3;
   localparam int SQS_W = TSQ_W + LOG2_WORDS;

   state_t                  state, state_nx;
   logic [LOG2_WORDS-1:0]   count;
   logic                    accept, last, open;

   logic signed [TREE_W-1:0]   ext_c  [LANES];
   logic        [SQ_W-1:0]     sq_c   [LANES];
   logic signed [SAMPLE_W-1:0] min_ch [LANES+1];
   logic signed [SAMPLE_W-1:0] max_ch [LANES+1];
   logic [3:0]                 unused_hi [LANES];

   logic                       s1_valid;
   logic signed [TREE_W-1:0]   s1_ext [LANES];
   logic        [SQ_W-1:0]     s1_sq  [LANES];
   logic signed [SAMPLE_W-1:0] s1_min, s1_max;

   logic signed [TREE_W-1:0]   word_sum;
   logic        [TSQ_W-1:0]    word_sq;

   assign accept = (state == ST_ACCUM) && valid_i;
   assign last   = accept && (count == '0);
   assign open   = start_i && ((state == ST_IDLE) || (state == ST_DONE));

   always_ff @(posedge clk) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start_i)   state_nx = ST_ACCUM;
         ST_ACCUM: if (last)      state_nx = ST_DRAIN;
         ST_DRAIN: if (!s1_valid) state_nx = ST_DONE;
         ST_DONE: begin
            if (start_i)    state_nx = ST_ACCUM;
            else if (ack_i) state_nx = ST_IDLE;
         end
         default:           state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state == ST_ACCUM) || (state == ST_DRAIN);
      done_o = (state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst_i)       count <= '0;
      else if (open)   count <= '1;
      else if (accept) count <= count - 1'b1;
   end

   assign min_ch[0] = MIN_INIT;
   assign max_ch[0] = MAX_INIT;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign unused_hi[k] = sim_data[LANE_W*k+SAMPLE_W +: 4];
      gaussian_stats_lane u_lane (
         .sample  (lane_sample(sim_data, k)),
         .min_in  (min_ch[k]),
         .max_in  (max_ch[k]),
         .ext     (ext_c[k]),
         .square  (sq_c[k]),
         .min_out (min_ch[k+1]),
         .max_out (max_ch[k+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst_i) s1_valid <= 1'b0;
      else       s1_valid <= accept;
   end

   // NOTE: S1 data registers carry no reset; s1_valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_ext <= ext_c;
         s1_sq  <= sq_c;
         s1_min <= min_ch[LANES];
         s1_max <= max_ch[LANES];
      end
   end

   // NOTE: blocking += is correct here; this is a combinational adder tree.
   always_comb begin
      word_sum = '0;
      word_sq  = '0;
      for (int k = 0; k < LANES; k++) begin
         word_sum += s1_ext[k];
         word_sq  += TSQ_W'(s1_sq[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i || open) begin
         sum_o   <= '0;
         sumsq_o <= '0;
         min_o   <= MIN_INIT;
         max_o   <= MAX_INIT;
      end else if (s1_valid) begin
         sum_o   <= sum_o + {{LOG2_WORDS{word_sum[TREE_W-1]}}, word_sum};
         sumsq_o <= sumsq_o + SQS_W'(word_sq);
         if (s1_min < min_o) min_o <= s1_min;
         if (s1_max > max_o) max_o <= s1_max;
      end
   end

`ifdef GAUSS_STATS_HIST_EN
   localparam int HIST_W = LOG2_WORDS + 4;

   logic [HIST_W-1:0] hist    [16];
   logic [3:0]        bin_inc [16];

   // Bin index is the raw two's-complement top nibble, so bin 8 holds the most negative samples
   always_comb begin
      for (int b = 0; b < 16; b++) begin
         bin_inc[b] = '0;
         for (int k = 0; k < LANES; k++)
            if (s1_ext[k][SAMPLE_W-1:SAMPLE_W-4] == 4'(b)) bin_inc[b] += 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i || open) begin
         for (int b = 0; b < 16; b++) hist[b] <= '0;
      end else if (s1_valid) begin
         for (int b = 0; b < 16; b++) hist[b] <= hist[b] + HIST_W'(bin_inc[b]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) hist_cnt_o <= '0;
      else       hist_cnt_o <= hist[hist_sel_i];
   end
`endif

endmodule
